// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents: arbiter state encoding and the UART byte width.
// Imported by the request interface, the picker and the arbiter top.
package uart_arb_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the UART transmit arbiter.
// Signals: req_valid/req_data/req_last from N_REQ producers, one-hot req_ready back.
// Modports: master = producers, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  import uart_arb_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ*UART_BYTE_W-1:0] req_data;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ-1:0]             req_ready;

  modport master (output req_valid, output req_data, output req_last, input req_ready);
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_req strictly after i_ptr, wrapping.
// Ports: i_req (request vector), i_ptr (last winner) -> o_hit (any request), o_win (winner index).
// Zero latency; no state, so it can be dropped into any arbiter.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_hit,
  output logic [IW-1:0] o_win
);

  logic [N-1:0] w_sh;

  // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1);
  // the last hit written is the nearest one after the pointer.
  always_comb begin
    o_hit = 1'b0;
    o_win = '0;
    w_sh  = '0;
    for (int k = N; k >= 1; k--) begin
      w_sh = i_req >> ((int'(i_ptr) + k) % N);
      if (w_sh[0]) begin
        o_hit = 1'b1;
        o_win = IW'((int'(i_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers, round-robin per byte
// (per packet when UART_ARB_LOCK_EN is defined: a granted requester keeps the grant until req_last).
// Ports: i_clk, i_rst (sync, active-high), req_if (slave), o_grant_id, o_busy,
//        o_uart_tx_data, o_uart_tx_valid, i_uart_tx_ready.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  uart_tx_arbiter_if.slave       req_if,
  output logic [ID_W-1:0]        o_grant_id,
  output logic                   o_busy,
  output logic [UART_BYTE_W-1:0] o_uart_tx_data,
  output logic                   o_uart_tx_valid,
  input  logic                   i_uart_tx_ready
);

  arb_state_t             r_state;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ID_W-1:0]        r_grant_id;
  logic [UART_BYTE_W-1:0] r_tx_data;
  logic                   r_tx_valid;

  logic [N_REQ-1:0]       w_elig;
  logic                   w_hit;
  logic [ID_W-1:0]        w_win;
  logic                   w_accept;

`ifdef UART_ARB_LOCK_EN
  logic r_lock;
  // Mid-packet only the current owner may be picked; the picker then lands on it.
  assign w_elig = r_lock ? (req_if.req_valid & (N_REQ'(1) << r_grant_id)) : req_if.req_valid;
`else
  logic w_unused_last;
  assign w_unused_last = ^req_if.req_last;
  assign w_elig        = req_if.req_valid;
`endif

  rr_pick #(.N(N_REQ)) u_pick (
    .i_req (w_elig),
    .i_ptr (r_rr_ptr),
    .o_hit (w_hit),
    .o_win (w_win)
  );

  // Accept only while idle and the transmitter reports idle; a reset cycle
  // accepts nothing so no byte is lost to it.
  assign w_accept         = (r_state == ST_ARB) && i_uart_tx_ready && w_hit && !i_rst;
  assign req_if.req_ready = w_accept ? (N_REQ'(1) << w_win) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_ARB;
      r_rr_ptr   <= ID_W'(N_REQ - 1);
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      r_lock     <= 1'b0;
`endif
    end else begin
      r_tx_valid <= 1'b0;
      case (r_state)
        ST_ARB: begin
          if (w_accept) begin
            r_tx_data  <= req_if.req_data[int'(w_win)*UART_BYTE_W +: UART_BYTE_W];
            r_grant_id <= w_win;
            r_tx_valid <= 1'b1;
            r_state    <= ST_ISSUE;
`ifdef UART_ARB_LOCK_EN
            if (!r_lock) r_rr_ptr <= w_win;
            r_lock <= !req_if.req_last[w_win];
`else
            r_rr_ptr   <= w_win;
`endif
          end
        end
        ST_ISSUE:     r_state <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (!i_uart_tx_ready) r_state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (i_uart_tx_ready)  r_state <= ST_ARB;
        default:      r_state <= ST_ARB;
      endcase
    end
  end

  assign o_grant_id      = r_grant_id;
  assign o_busy          = (r_state != ST_ARB);
  assign o_uart_tx_data  = r_tx_data;
  assign o_uart_tx_valid = r_tx_valid;

endmodule
